// File: rtl/ls191_checker_if.sv
// ls191_checker_if: stimulus and output bundle shared by a '191 counter and its checker
interface ls191_checker_if;
    logic down_up, g, ld, a, b, c, d;
    logic qa, qb, qc, qd, m_m;
    modport master (output down_up, g, ld, a, b, c, d, qa, qb, qc, qd, m_m);
    modport slave (input down_up, g, ld, a, b, c, d, qa, qb, qc, qd, m_m);
endinterface

// File: rtl/ls191_checker.sv
// ls191_checker: tracks an expected '191 count and flags count or max/min mismatches
module ls191_checker #(
    parameter int ERR_W = 8,
    parameter int CHK_W = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    ls191_checker_if.slave   bus,
    output logic [3:0]       exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CHK_W-1:0] chk_cnt,
    output logic             fail,
    output logic [3:0]       first_exp,
    output logic [3:0]       first_act
);
    typedef enum logic [1:0] {IDLE, TRACK, HALT} state_t;
    state_t state;
    logic [3:0] q, data;
    logic exp_mm, match;
    always_comb begin
        q = {bus.qd, bus.qc, bus.qb, bus.qa};
        data = {bus.d, bus.c, bus.b, bus.a};
        exp_mm = bus.down_up ? (exp_q == 4'h0) : (exp_q == 4'hf);
        match = (q == exp_q) && (bus.m_m == exp_mm);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            exp_q <= '0;
            exp_valid <= 1'b0;
            err <= 1'b0;
            err_cnt <= '0;
            chk_cnt <= '0;
            fail <= 1'b0;
            first_exp <= '0;
            first_act <= '0;
        end else if (clear) begin
            state <= IDLE;
            exp_q <= '0;
            exp_valid <= 1'b0;
            err <= 1'b0;
            err_cnt <= '0;
            chk_cnt <= '0;
            fail <= 1'b0;
            first_exp <= '0;
            first_act <= '0;
        end else begin
            err <= 1'b0;
            if (state != HALT) begin
                if (!bus.ld) begin
                    exp_q <= data;
                    exp_valid <= 1'b1;
                    state <= TRACK;
                end else if (state == TRACK) begin
                    if (!bus.g) exp_q <= bus.down_up ? exp_q - 4'd1 : exp_q + 4'd1;
                    if (chk_cnt != '1) chk_cnt <= chk_cnt + CHK_W'(1);
                    // an unknown match falls to the else branch, so X/Z on q is a mismatch
                    if (match) err <= 1'b0;
                    else begin
                        err <= 1'b1;
                        fail <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                        if (!fail) begin
                            first_exp <= exp_q;
                            first_act <= q;
                        end
                        if (STOP_ON_ERR != 0) state <= HALT;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ls191_checker.sv
// tb_ls191_checker: directed vectors against three checker configurations sharing one stimulus bus
module tb_ls191_checker;
    logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic [3:0] cnt = 4'd0;
    int errors = 0, checks = 0;
    ls191_checker_if bus ();
    logic [3:0] exp_q0, exp_q1, exp_q2, fe0, fe1, fe2, fa0, fa1, fa2;
    logic ev0, ev1, ev2, err0, err1, err2, fail0, fail1, fail2;
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;
    logic [15:0] cc0, cc1, cc2;
    logic [3:0] up_exp [3] = '{4'd15, 4'd0, 4'd1};
    logic [3:0] dn_exp [3] = '{4'd0, 4'd15, 4'd14};
    wire [38:0] all0 = {exp_q0, ev0, err0, ec0, cc0, fail0, fe0, fa0};
    wire [38:0] all1 = {exp_q1, ev1, err1, ec1, cc1, fail1, fe1, fa1};
    wire [32:0] all2 = {exp_q2, ev2, err2, ec2, cc2, fail2, fe2, fa2};

    always #5 clk = ~clk;

    ls191_checker dut0 (.clk(clk), .rst(rst), .clear(clear), .bus(bus), .exp_q(exp_q0), .exp_valid(ev0),
        .err(err0), .err_cnt(ec0), .chk_cnt(cc0), .fail(fail0), .first_exp(fe0), .first_act(fa0));
    ls191_checker #(.STOP_ON_ERR(1)) dut1 (.clk(clk), .rst(rst), .clear(clear), .bus(bus), .exp_q(exp_q1),
        .exp_valid(ev1), .err(err1), .err_cnt(ec1), .chk_cnt(cc1), .fail(fail1), .first_exp(fe1), .first_act(fa1));
    ls191_checker #(.ERR_W(2)) dut2 (.clk(clk), .rst(rst), .clear(clear), .bus(bus), .exp_q(exp_q2),
        .exp_valid(ev2), .err(err2), .err_cnt(ec2), .chk_cnt(cc2), .fail(fail2), .first_exp(fe2), .first_act(fa2));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // drives one edge of a well-behaved counter; qf/mf corrupt its outputs
    task automatic step(input logic l, input logic gg, input logic dn, input logic [3:0] data,
                        input logic [3:0] qf, input logic mf);
        @(negedge clk);
        bus.ld = l;
        bus.g = gg;
        bus.down_up = dn;
        {bus.d, bus.c, bus.b, bus.a} = data;
        {bus.qd, bus.qc, bus.qb, bus.qa} = cnt ^ qf;
        bus.m_m = ((dn && cnt == 4'd0) || (!dn && cnt == 4'd15)) ^ mf;
        @(posedge clk);
        #1;
        if (!l) cnt = data;
        else if (!gg) cnt = dn ? cnt - 4'd1 : cnt + 4'd1;
    endtask

    task automatic clr();
        @(negedge clk);
        clear = 1'b1;
        bus.ld = 1'b0;
        {bus.d, bus.c, bus.b, bus.a} = 4'd9;
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.ld = 1'b1;
    endtask

    initial begin
        bus.ld = 1'b1; bus.g = 1'b1; bus.down_up = 1'b0; bus.m_m = 1'b0;
        {bus.d, bus.c, bus.b, bus.a} = 4'd0;
        {bus.qd, bus.qc, bus.qb, bus.qa} = 4'd0;
        #12;
        check("rst_dut0", all0, 0);
        check("rst_dut1", all1, 0);
        check("rst_dut2", all2, 0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'h5, 1'b0);
        check("idle_chk", cc0, 0);
        check("idle_err", err0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0);
        check("load_q", exp_q0, 5);
        check("load_valid", ev0, 1);
        check("load_nochk", cc0, 0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("up_q", exp_q0, 13);
        check("up_chk", cc0, 8);
        check("up_err", err0, 0);
        check("up_fail", fail0, 0);
        clr();
        check("clear_over_load", all0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd14, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
            check("wrap_up_q", exp_q0, up_exp[i]);
        end
        step(1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
            check("wrap_dn_q", exp_q0, dn_exp[i]);
        end
        check("wrap_chk", cc0, 6);
        check("wrap_errcnt", ec0, 0);
        check("wrap_fail", fail0, 0);
        clr();
        step(1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("hold_q", exp_q0, 7);
        check("hold_chk", cc0, 5);
        check("hold_errcnt", ec0, 0);
        clr();
        step(1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'b0010, 1'b0);
        check("f1_err", err0, 1);
        check("f1_errcnt", ec0, 1);
        check("f1_fail", fail0, 1);
        check("f1_first_exp", fe0, 6);
        check("f1_first_act", fa0, 4);
        check("f1_q", exp_q0, 7);
        check("f1_chk", cc0, 4);
        check("stop_err", err1, 1);
        check("stop_errcnt", ec1, 1);
        check("stop_q", exp_q1, 7);
        check("stop_chk", cc1, 4);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("pulse_end", err0, 0);
        check("ok_q", exp_q0, 8);
        check("ok_chk", cc0, 5);
        check("halt_err", err1, 0);
        check("halt_q", exp_q1, 7);
        check("halt_chk", cc1, 4);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        check("f2_err", err0, 1);
        check("f2_errcnt", ec0, 2);
        check("f2_first", {fe0, fa0}, 8'h64);
        check("halt_errcnt", ec1, 1);
        check("halt_chk2", cc1, 4);
        clr();
        check("stop_clear", all1, 0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("stop_idle_chk", cc1, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0);
        check("sat_errcnt", ec2, 3);
        check("sat_chk", cc2, 5);
        check("sat_fail", fail2, 1);
        check("nosat_errcnt", ec0, 5);
        check("halt_errcnt2", ec1, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst0", all0, 0);
        check("async_rst1", all1, 0);
        check("async_rst2", all2, 0);
        #1 rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'h3, 1'b0);
        check("post_rst_chk", cc2, 0);
        check("post_rst_valid", ev2, 0);
        check("post_rst_err", err2, 0);
        step(1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 1'b0);
        check("post_rst_load", {exp_q2, ev2}, 5'h13);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
